xc_rf_fwd_sb: RTL and testbench
===============================

Name: xc_rf_fwd_sb

Overview:
- Parametrised multi-port GPR file with N-stage operand forwarding and a per-register pending scoreboard.
- Sits between decode and the execute pipeline and replaces the fixed 3-read/2-forward register file.
- New versus the previous generation: configurable read-port count, forwarding depth and register count; forwarding is gated by each stage's write-enable; per-operand ready signalling; flush.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers. Must be a power of two, at least 2.
- AW, $clog2(NREGS), register address width. Derived; do not override.
- NREAD, 3, number of read ports, 1 to 4.
- NFWD, 2, number of forwarding stages, 0 to 4. Stage 0 is the youngest.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- rs_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rs_rdata  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rs_ready  out  NREAD  port i operand is valid this cycle.
- fwd_wen  in  NFWD  forwarding stage k holds a valid result.
- fwd_addr  in  NFWD*AW  destination address of stage k.
- fwd_wdata  in  NFWD*XLEN  result data of stage k.
- rd_wen  in  1  writeback enable.
- rd_addr  in  AW  writeback address.
- rd_wdata  in  XLEN  writeback data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  AW  destination of the issuing instruction.
- flush  in  1  synchronous clear of all pending bits.
- pend_any  out  1  at least one pending bit is set (registered state, combinationally ORed).

Behaviour:
- Storage: NREGS x XLEN registers. Register 0 always reads 0 and is never written. Reset clears all storage to 0.
- Write: on the rising edge, if rd_wen=1 and rd_addr!=0, reg[rd_addr] <= rd_wdata. The write is visible in storage from the next cycle.
- Read data per port i (combinational, zero latency), first match wins:
  - rs_addr_i==0 -> 0.
  - Lowest k with fwd_wen[k]=1 and fwd_addr[k]==rs_addr_i -> fwd_wdata[k].
  - rd_wen=1 and rd_addr==rs_addr_i -> rd_wdata (write-through).
  - Otherwise reg[rs_addr_i].
- A forwarding stage with fwd_wen=0 never supplies data, even when its address matches.
- Scoreboard: NREGS pending bits; bit 0 is hardwired to 0.
  - Next state for register r (r!=0):
    - flush=1 -> 0.
    - iss_valid=1 and iss_addr==r -> 1. Set wins over a same-cycle clear.
    - rd_wen=1 and rd_addr==r -> 0.
    - Otherwise hold.
  - flush clears every bit, including one being issued in the same cycle.
  - iss_valid with iss_addr==0 has no effect.
- rs_ready_i = 1 when any of the following holds:
  - rs_addr_i==0;
  - a forwarding hit exists for the port;
  - a write-through hit exists for the port;
  - pending[rs_addr_i]==0.
  
  Otherwise rs_ready_i = 0. The current cycle's iss_valid does not affect rs_ready in the same cycle.
- Reset: asynchronous; storage and pending bits go to 0 immediately.
  - While resetn=0, writes and issues are ignored.
  - While resetn=0, pend_any=0 and every rs_ready=1. rs_rdata returns a forwarding or write-through hit if present, otherwise 0.
  - Reset asserted mid-operation discards all pending bits.
- NFWD=0: the forwarding ports are absent in effect (zero width); priority starts at write-through.
- All addresses are interpreted modulo NREGS; no out-of-range addresses exist.

Test Plan:
- Reset, then read addresses 0, 5 and 31 on all ports -> rdata 0 and ready 1 for every port; pend_any 0.
- Write reg5=0xDEADBEEF. Next cycle set fwd_wen=2'b10, fwd_addr[1]=5, fwd_wdata[1]=0x11111111, and fwd_wen[0]=0 with fwd_addr[0]=5 -> rs 5 reads 0x11111111. Then set fwd_wen=2'b11 with fwd_wdata[0]=0x22222222 -> reads 0x22222222.
- Issue iss_addr=7. Next cycle read rs 7 -> ready 0 and pend_any 1. Drive rd_wen with rd_addr=7, rd_wdata=0x0000ABCD -> same cycle ready 1 and rdata 0x0000ABCD. Following cycle: pending clear, storage reads 0x0000ABCD.
- Same cycle rd_wen with rd_addr=9 and iss_valid with iss_addr=9, register 9 previously pending -> after the edge, pending[9]=1 and rs 9 ready 0.
- Issue to registers 3 and 4, then assert flush with iss_addr=3 in the same cycle -> next cycle pend_any 0; ready 1 for both registers.
- Write reg0=0xFFFFFFFF, issue to 0, forward to 0 -> rs 0 reads 0 with ready 1. Assert resetn low mid-pending -> pend_any drops to 0 asynchronously.

Source files
------------

// File: rtl/xc_rf_fwd_sb.sv
// Purpose : multi-port GPR file with N-stage operand forwarding and a per-register pending scoreboard.
// Latency : reads are combinational (zero cycles); writes, issues and flushes take effect after the rising edge.
// Backpress: none; rs_ready tells decode which operands are usable this cycle, stalling is up to the caller.
//
// Ports:
//   clock, resetn                 clock and asynchronous active-low reset
//   rs_addr / rs_rdata / rs_ready NREAD packed read ports (address, data, operand-valid)
//   fwd_wen / fwd_addr / fwd_wdata NFWD packed forwarding stages, stage 0 youngest
//   rd_wen / rd_addr / rd_wdata   writeback port (also forwarded write-through)
//   iss_valid / iss_addr          destination of the issuing instruction (sets pending)
//   flush                         clears every pending bit
//   pend_any                      OR of all pending bits
module xc_rf_fwd_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NREAD = 3,
    parameter int NFWD  = 2,
    // Forwarding buses keep one dummy lane when NFWD=0 so the ports stay legal.
    parameter int FW    = (NFWD > 0) ? NFWD : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_rdata,
    output logic [NREAD-1:0]      rs_ready,
    input  logic [FW-1:0]         fwd_wen,
    input  logic [FW*AW-1:0]      fwd_addr,
    input  logic [FW*XLEN-1:0]    fwd_wdata,
    input  logic                  rd_wen,
    input  logic [AW-1:0]         rd_addr,
    input  logic [XLEN-1:0]       rd_wdata,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic                  pend_any
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;

    // Storage: register 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (rd_wen && (rd_addr != '0)) begin
            regs[rd_addr] <= rd_wdata;
        end
    end

    // Scoreboard next state. Priority per register: flush, then issue-set,
    // then writeback-clear, so an instruction re-targeting a register that is
    // retiring in the same cycle keeps it pending.
    always_comb begin
        pend_nxt = pend;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                pend_nxt[r] = 1'b0;
            end else if (iss_valid && (iss_addr == AW'(r))) begin
                pend_nxt[r] = 1'b1;
            end else if (rd_wen && (rd_addr == AW'(r))) begin
                pend_nxt[r] = 1'b0;
            end
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign pend_any = |pend;

    // Read ports. Forwarding stages are scanned oldest to youngest so the
    // youngest matching, enabled stage is the one left standing.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic            fwd_hit;
        logic [XLEN-1:0] fwd_dat;
        logic            wb_hit;

        assign a = rs_addr[i*AW +: AW];

        always_comb begin
            fwd_hit = 1'b0;
            fwd_dat = '0;
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_wen[k] && (fwd_addr[k*AW +: AW] == a)) begin
                    fwd_hit = 1'b1;
                    fwd_dat = fwd_wdata[k*XLEN +: XLEN];
                end
            end
        end

        assign wb_hit = rd_wen && (rd_addr == a);

        assign rs_rdata[i*XLEN +: XLEN] = (a == '0) ? '0       :
                                          fwd_hit   ? fwd_dat  :
                                          wb_hit    ? rd_wdata :
                                                      regs[a];

        // A bypass hit supplies the value even if the scoreboard still shows it in flight.
        assign rs_ready[i] = (a == '0) || fwd_hit || wb_hit || !pend[a];
    end

endmodule

// File: tb/tb_xc_rf_fwd_sb.sv
module tb_xc_rf_fwd_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NREAD = 3;
    localparam int NFWD  = 2;

    logic                  clock;
    logic                  resetn;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_rdata;
    logic [NREAD-1:0]      rs_ready;
    logic [NFWD-1:0]       fwd_wen;
    logic [NFWD*AW-1:0]    fwd_addr;
    logic [NFWD*XLEN-1:0]  fwd_wdata;
    logic                  rd_wen;
    logic [AW-1:0]         rd_addr;
    logic [XLEN-1:0]       rd_wdata;
    logic                  iss_valid;
    logic [AW-1:0]         iss_addr;
    logic                  flush;
    logic                  pend_any;

    xc_rf_fwd_sb #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NREAD(NREAD),
        .NFWD (NFWD)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .rs_addr  (rs_addr),
        .rs_rdata (rs_rdata),
        .rs_ready (rs_ready),
        .fwd_wen  (fwd_wen),
        .fwd_addr (fwd_addr),
        .fwd_wdata(fwd_wdata),
        .rd_wen   (rd_wen),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pend_any (pend_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: architectural contents and which registers are in flight.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_pend [NREGS];

    typedef struct {
        logic [XLEN-1:0] rdata [NREAD];
        logic            ready [NREAD];
        logic            pend_any;
    } exp_t;

    exp_t sb[$];

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic void model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_pend[r] = 0;
        end
    endfunction

    // Value an operand should see: register 0 is zero; otherwise the youngest
    // enabled forwarding stage naming it, then the retiring writeback, then storage.
    function automatic exp_t model_expect();
        exp_t e;
        e.pend_any = 1'b0;
        for (int r = 0; r < NREGS; r++) if (m_pend[r]) e.pend_any = 1'b1;
        for (int i = 0; i < NREAD; i++) begin
            int a;
            int src;
            a   = int'(rs_addr[i*AW +: AW]);
            src = -1;
            for (int k = 0; k < NFWD; k++)
                if (src < 0 && fwd_wen[k] && int'(fwd_addr[k*AW +: AW]) == a) src = k;
            if (a == 0) begin
                e.rdata[i] = '0;
                e.ready[i] = 1'b1;
            end else if (src >= 0) begin
                e.rdata[i] = fwd_wdata[src*XLEN +: XLEN];
                e.ready[i] = 1'b1;
            end else if (rd_wen && int'(rd_addr) == a) begin
                e.rdata[i] = rd_wdata;
                e.ready[i] = 1'b1;
            end else begin
                e.rdata[i] = m_reg[a];
                e.ready[i] = !m_pend[a];
            end
        end
        return e;
    endfunction

    function automatic void model_update();
        if (rd_wen && rd_addr != 0) m_reg[rd_addr] = rd_wdata;
        if (flush) begin
            for (int r = 0; r < NREGS; r++) m_pend[r] = 0;
        end else begin
            if (rd_wen) m_pend[rd_addr] = 0;
            if (iss_valid) m_pend[iss_addr] = 1;  // set after clear: issue wins
        end
        m_pend[0] = 0;
    endfunction

    // Inputs are already driven for this cycle: record what the DUT must show
    // before the next edge, advance the model, then move to the next cycle.
    task automatic step();
        if (!resetn) model_clear();
        sb.push_back(model_expect());
        if (resetn) model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fwd_wen   = '0;
        fwd_addr  = '0;
        fwd_wdata = '0;
        rd_wen    = 1'b0;
        rd_addr   = '0;
        rd_wdata  = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        flush     = 1'b0;
    endtask

    task automatic set_rs(input int a0, input int a1, input int a2);
        rs_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    // Monitor: outputs are settled mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int i = 0; i < NREAD; i++) begin
                chk($sformatf("rdata%0d", i), rs_rdata[i*XLEN +: XLEN], e.rdata[i]);
                chk($sformatf("ready%0d", i), XLEN'(rs_ready[i]), XLEN'(e.ready[i]));
            end
            chk("pend_any", XLEN'(pend_any), XLEN'(e.pend_any));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn  = 1'b0;
        rs_addr = '0;
        idle();
        model_clear();
        @(posedge clock);
        #1;

        // Reset: everything reads zero and ready.
        set_rs(0, 5, 31);
        step();
        resetn = 1'b1;
        step();

        // Write 5, then forwarding priority with stage gating.
        set_rs(5, 5, 5);
        rd_wen = 1'b1; rd_addr = 5; rd_wdata = 32'hDEADBEEF;
        step();
        idle();
        fwd_wen   = 2'b10;
        fwd_addr  = {AW'(5), AW'(5)};
        fwd_wdata = {32'h11111111, 32'h99999999};
        step();
        fwd_wen   = 2'b11;
        fwd_wdata = {32'h11111111, 32'h22222222};
        step();
        idle();
        step();

        // Issue 7, observe pending, write-through on retire, then cleared.
        set_rs(7, 0, 5);
        iss_valid = 1'b1; iss_addr = 7;
        step();
        idle();
        step();
        rd_wen = 1'b1; rd_addr = 7; rd_wdata = 32'h0000ABCD;
        step();
        idle();
        step();

        // Same-cycle issue and writeback to a pending register: stays pending.
        set_rs(9, 7, 9);
        iss_valid = 1'b1; iss_addr = 9;
        step();
        rd_wen = 1'b1; rd_addr = 9; rd_wdata = 32'h12345678;
        step();
        idle();
        step();

        // Flush beats a same-cycle issue.
        set_rs(3, 4, 9);
        iss_valid = 1'b1; iss_addr = 3;
        step();
        iss_addr = 4;
        step();
        iss_addr = 3; flush = 1'b1;
        step();
        idle();
        step();

        // Register 0: ignores write, issue and forwarding.
        set_rs(0, 0, 0);
        rd_wen = 1'b1; rd_addr = 0; rd_wdata = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_addr = 0;
        fwd_wen = 2'b01; fwd_addr = '0; fwd_wdata = {32'h0, 32'h5A5A5A5A};
        step();
        idle();
        step();

        // Reset asserted while a register is pending.
        set_rs(12, 5, 7);
        iss_valid = 1'b1; iss_addr = 12;
        step();
        idle();
        step();
        resetn = 1'b0;
        #1;
        chk("async_pend_any", XLEN'(pend_any), '0);
        chk("async_ready12", XLEN'(rs_ready[0]), 32'd1);
        step();
        resetn = 1'b1;
        step();

        // Randomised traffic with addresses concentrated to force hits.
        for (int n = 0; n < 400; n++) begin
            int a[NREAD];
            for (int i = 0; i < NREAD; i++)
                a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1))
                                                   : int'($urandom_range(0, 7));
            set_rs(a[0], a[1], a[2]);
            fwd_wen   = NFWD'($urandom);
            fwd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            fwd_wdata = {$urandom, $urandom};
            rd_wen    = $urandom_range(0, 1) == 1;
            rd_addr   = AW'($urandom_range(0, 7));
            rd_wdata  = $urandom;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_addr  = AW'($urandom_range(0, 7));
            flush     = $urandom_range(0, 19) == 0;
            step();
        end
        idle();
        step();

        for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clock);
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
